// File: rtl/mtl_lcd_pkg.sv
// Shared timing constants, pixel types and the NES master palette for the MTL LCD transmitter.
package mtl_lcd_pkg;

  localparam int unsigned H_TOTAL     = 1056;
  localparam int unsigned V_TOTAL     = 525;
  localparam int unsigned HSYNC_W     = 30;
  localparam int unsigned VSYNC_W     = 13;
  localparam int unsigned H_ACT_START = 50;
  localparam int unsigned V_ACT_START = 23;
  localparam int unsigned H_ACT       = 800;
  localparam int unsigned V_ACT       = 480;
  localparam int unsigned IMG_X0      = 144;
  localparam int unsigned IMG_W       = 512;
  localparam logic [5:0]  BORDER_IDX  = 6'h0F;

  typedef logic [23:0] rgb24_t;

  // Panel control flags that travel down the pipeline alongside the pixel.
  typedef struct packed {
    logic de;
    logic hsd;
    logic vsd;
    logic fs;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{de: 1'b0, hsd: 1'b1, vsd: 1'b1, fs: 1'b0};

  localparam rgb24_t NES_PALETTE [64] = '{
    24'h666666, 24'h002A88, 24'h1412A7, 24'h3B00A4, 24'h5C007E, 24'h6E0040, 24'h6C0600, 24'h561D00,
    24'h333500, 24'h0B4800, 24'h005200, 24'h004F08, 24'h00404D, 24'h000000, 24'h000000, 24'h000000,
    24'hADADAD, 24'h155FD9, 24'h4240FF, 24'h7527FE, 24'hA01ACC, 24'hB71E7B, 24'hB53120, 24'h994E00,
    24'h6B6D00, 24'h388700, 24'h0C9300, 24'h008F32, 24'h007C8D, 24'h000000, 24'h000000, 24'h000000,
    24'hFFFEFF, 24'h64B0FF, 24'h9290FF, 24'hC676FF, 24'hF36AFF, 24'hFE6ECC, 24'hFE8170, 24'hEA9E22,
    24'hBCBE00, 24'h88D800, 24'h5CE430, 24'h45E082, 24'h48CDDE, 24'h4F4F4F, 24'h000000, 24'h000000,
    24'hFFFEFF, 24'hC0DFFF, 24'hD3D2FF, 24'hE8C8FF, 24'hFBC2FF, 24'hFEC4EA, 24'hFECCC5, 24'hF7D8A5,
    24'hE4E594, 24'hCFEF96, 24'hBDF4AB, 24'hB3F3CC, 24'hB5EBF2, 24'hB8B8B8, 24'h000000, 24'h000000
  };

endpackage

// File: rtl/mtl_lcd_tx_palette.sv
// Registered NES palette lookup; its output register is the final RGB pipeline stage.
module nes_palette_rom
  import mtl_lcd_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic [5:0] i_idx,
  output rgb24_t     o_rgb
);

  rgb24_t rgb_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) rgb_q <= '0;
    else         rgb_q <= NES_PALETTE[i_idx];
  end

  assign o_rgb = rgb_q;

endmodule

// File: rtl/mtl_lcd_tx.sv
// MTL 800x480 panel timing generator with 2x-scaled NES frame buffer fetch and palette conversion.
module mtl_lcd_tx
  import mtl_lcd_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rstn,
  output logic        o_rd_en,
  output logic [15:0] o_rd_addr,
  input  logic [5:0]  i_rd_idx,
  output logic        o_hsd,
  output logic        o_vsd,
  output logic        o_de,
  output logic [7:0]  o_r,
  output logic [7:0]  o_g,
  output logic [7:0]  o_b,
  output logic        o_frame_start,
  output logic        o_vblank
);

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0] HS_END   = 11'(HSYNC_W);
  localparam logic [9:0]  VS_END   = 10'(VSYNC_W);
  localparam logic [10:0] HA_START = 11'(H_ACT_START);
  localparam logic [10:0] HA_END   = 11'(H_ACT_START + H_ACT);
  localparam logic [9:0]  VA_START = 10'(V_ACT_START);
  localparam logic [9:0]  VA_END   = 10'(V_ACT_START + V_ACT);
  localparam logic [10:0] IMG_S    = 11'(H_ACT_START + IMG_X0);
  localparam logic [10:0] IMG_E    = 11'(H_ACT_START + IMG_X0 + IMG_W);

  logic [10:0] h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;

  always_comb begin
    h_cnt_d = h_cnt_q + 11'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  logic        h_act, v_act, img_raw;
  logic [10:0] img_x;
  logic [9:0]  img_y;
  logic [15:0] rd_addr_d;
  ctl_t        ctl_raw;

  always_comb begin
    h_act       = (h_cnt_q >= HA_START) && (h_cnt_q < HA_END);
    v_act       = (v_cnt_q >= VA_START) && (v_cnt_q < VA_END);
    ctl_raw.de  = h_act && v_act;
    ctl_raw.hsd = (h_cnt_q >= HS_END);
    ctl_raw.vsd = (v_cnt_q >= VS_END);
    ctl_raw.fs  = (h_cnt_q == '0) && (v_cnt_q == '0);
    img_raw     = ctl_raw.de && (h_cnt_q >= IMG_S) && (h_cnt_q < IMG_E);
    img_x       = h_cnt_q - IMG_S;
    img_y       = v_cnt_q - VA_START;
    rd_addr_d   = {8'(img_y >> 1), 8'(img_x >> 1)};
  end

  assign o_vblank = !v_act;

  logic        rd_en_q, img2_q;
  logic [15:0] rd_addr_q;
  ctl_t        ctl1_q, ctl2_q, ctl3_q;

  // Control flags take three register stages so they land with the palette register's output.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      img2_q    <= 1'b0;
      ctl1_q    <= CTL_IDLE;
      ctl2_q    <= CTL_IDLE;
      ctl3_q    <= CTL_IDLE;
    end else begin
      rd_en_q <= img_raw;
      if (img_raw) rd_addr_q <= rd_addr_d;
      img2_q  <= rd_en_q;
      ctl1_q  <= ctl_raw;
      ctl2_q  <= ctl1_q;
      ctl3_q  <= ctl2_q;
    end
  end

  logic [5:0] sel_idx;
  rgb24_t     rom_rgb, pix_rgb;

  assign sel_idx = img2_q ? i_rd_idx : BORDER_IDX;

  nes_palette_rom u_rom (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_idx  (sel_idx),
    .o_rgb  (rom_rgb)
  );

  assign pix_rgb       = ctl3_q.de ? rom_rgb : '0;
  assign o_rd_en       = rd_en_q;
  assign o_rd_addr     = rd_addr_q;
  assign o_hsd         = ctl3_q.hsd;
  assign o_vsd         = ctl3_q.vsd;
  assign o_de          = ctl3_q.de;
  assign o_frame_start = ctl3_q.fs;
  assign o_r           = pix_rgb[23:16];
  assign o_g           = pix_rgb[15:8];
  assign o_b           = pix_rgb[7:0];

endmodule
